// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline register with a two-entry skid buffer, synchronous flush
// and a saturating count of MEM back-pressure cycles.
module ex_mem_skid_reg #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] ALUResult_i,
    input  logic [DATA_W-1:0] WriteData_i,
    input  logic [DATA_W-1:0] PCPlus4_i,
    input  logic              Zero_i,
    input  logic [RD_W-1:0]   Rd_i,
    input  logic              RegWrite_i,
    input  logic              MemWrite_i,
    input  logic [1:0]        ResultSrc_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ALUResult_o,
    output logic [DATA_W-1:0] WriteData_o,
    output logic [DATA_W-1:0] PCPlus4_o,
    output logic              Zero_o,
    output logic [RD_W-1:0]   Rd_o,
    output logic              RegWrite_o,
    output logic              MemWrite_o,
    output logic [1:0]        ResultSrc_o,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int BUNDLE_W = 3 * DATA_W + RD_W + 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [BUNDLE_W-1:0] r_main;
    logic [BUNDLE_W-1:0] r_skid;
    logic [CNT_W-1:0]    r_stallCnt;
    logic [BUNDLE_W-1:0] w_inBundle;
    logic                w_acc;
    logic                w_pop;
    logic                w_loadMainFromIn;
    logic                w_loadMainFromSkid;
    logic                w_loadSkid;

    assign w_inBundle = {ALUResult_i, WriteData_i, PCPlus4_i, Zero_i,
                         Rd_i, RegWrite_i, MemWrite_i, ResultSrc_i};

    assign {ALUResult_o, WriteData_o, PCPlus4_o, Zero_o,
            Rd_o, RegWrite_o, MemWrite_o, ResultSrc_o} = r_main;

    // in_ready is a pure decode of the state register, so it never depends on out_ready
    assign out_valid = (r_state != EMPTY);
    assign in_ready  = (r_state != FULL);
    assign w_acc     = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign stall_cnt = r_stallCnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState        = r_state;
        w_loadMainFromIn   = 1'b0;
        w_loadMainFromSkid = 1'b0;
        w_loadSkid         = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_acc) begin
                    w_loadMainFromIn = 1'b1;
                    w_nextState      = BUSY;
                end
            end
            BUSY: begin
                if (w_acc && w_pop) begin
                    w_loadMainFromIn = 1'b1;
                end else if (w_acc) begin
                    w_loadSkid  = 1'b1;
                    w_nextState = FULL;
                end else if (w_pop) begin
                    w_nextState = EMPTY;
                end
            end
            FULL: begin
                if (w_pop) begin
                    w_loadMainFromSkid = 1'b1;
                    w_nextState        = BUSY;
                end
            end
            default: w_nextState = EMPTY;
        endcase
        // Flush only clears validity; the data registers keep their stale contents
        if (flush) begin
            w_nextState        = EMPTY;
            w_loadMainFromIn   = 1'b0;
            w_loadMainFromSkid = 1'b0;
            w_loadSkid         = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_loadMainFromIn) begin
                r_main <= w_inBundle;
            end else if (w_loadMainFromSkid) begin
                r_main <= r_skid;
            end
            if (w_loadSkid) begin
                r_skid <= w_inBundle;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stallCnt <= '0;
        end else if (out_valid && !out_ready && (r_stallCnt != '1)) begin
            r_stallCnt <= r_stallCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Self-checking bench for ex_mem_skid_reg: directed vector table, hand-written
// corner sequences and random traffic against a queue-based reference model.
module tb_ex_mem_skid_reg;

    localparam int DATA_W = 32;
    localparam int RD_W   = 5;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] pc4;
        logic              zero;
        logic [RD_W-1:0]   rd;
        logic              regWrite;
        logic              memWrite;
        logic [1:0]        resultSrc;
    } bundle_t;

    typedef struct {
        logic        iv;
        logic        oRdy;
        logic        fl;
        logic [31:0] alu;
        logic        expOv;
        logic        expIr;
        logic        chkAlu;
        logic [31:0] expAlu;
        int          expCnt;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] ALUResult_i, WriteData_i, PCPlus4_i;
    logic              Zero_i;
    logic [RD_W-1:0]   Rd_i;
    logic              RegWrite_i, MemWrite_i;
    logic [1:0]        ResultSrc_i;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] ALUResult_o, WriteData_o, PCPlus4_o;
    logic              Zero_o;
    logic [RD_W-1:0]   Rd_o;
    logic              RegWrite_o, MemWrite_o;
    logic [1:0]        ResultSrc_o;
    logic [CNT_W-1:0]  stall_cnt;

    bundle_t modelQ[$];
    int      modelCnt;
    int      checks;
    int      failures;
    vec_t    vecs[$];

    always #5 clk = ~clk;

    ex_mem_skid_reg #(.DATA_W(DATA_W), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALUResult_i(ALUResult_i), .WriteData_i(WriteData_i), .PCPlus4_i(PCPlus4_i),
        .Zero_i(Zero_i), .Rd_i(Rd_i), .RegWrite_i(RegWrite_i), .MemWrite_i(MemWrite_i),
        .ResultSrc_i(ResultSrc_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUResult_o(ALUResult_o), .WriteData_o(WriteData_o), .PCPlus4_o(PCPlus4_o),
        .Zero_o(Zero_o), .Rd_o(Rd_o), .RegWrite_o(RegWrite_o), .MemWrite_o(MemWrite_o),
        .ResultSrc_o(ResultSrc_o),
        .stall_cnt(stall_cnt)
    );

    function automatic vec_t mkVec(logic iv, logic oRdy, logic fl, logic [31:0] alu,
                                   logic expOv, logic expIr, logic chkAlu,
                                   logic [31:0] expAlu, int expCnt);
        vec_t v;
        v.iv = iv; v.oRdy = oRdy; v.fl = fl; v.alu = alu;
        v.expOv = expOv; v.expIr = expIr; v.chkAlu = chkAlu;
        v.expAlu = expAlu; v.expCnt = expCnt;
        return v;
    endfunction

    function automatic bundle_t inBundle();
        return {ALUResult_i, WriteData_i, PCPlus4_i, Zero_i,
                Rd_i, RegWrite_i, MemWrite_i, ResultSrc_i};
    endfunction

    function automatic bundle_t outBundle();
        return {ALUResult_o, WriteData_o, PCPlus4_o, Zero_o,
                Rd_o, RegWrite_o, MemWrite_o, ResultSrc_o};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: the buffer is a FIFO of depth two; one edge = optional pop then optional push
    task automatic applyStimulus();
        bit doAcc;
        bit doPop;
        doAcc = in_valid && (modelQ.size() < 2);
        doPop = (modelQ.size() > 0) && out_ready;
        if ((modelQ.size() > 0) && !out_ready && (modelCnt < CNT_MAX)) modelCnt++;
        if (flush) begin
            modelQ.delete();
        end else begin
            if (doPop) void'(modelQ.pop_front());
            if (doAcc) modelQ.push_back(inBundle());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".out_valid"}, 128'(out_valid), 128'(modelQ.size() > 0));
        check({tag, ".in_ready"}, 128'(in_ready), 128'(modelQ.size() < 2));
        check({tag, ".stall_cnt"}, 128'(stall_cnt), 128'(modelCnt));
        if (modelQ.size() > 0 && out_valid)
            check({tag, ".bundle"}, 128'(outBundle()), 128'(modelQ[0]));
    endtask

    task automatic driveFields(input logic [31:0] alu);
        ALUResult_i = alu;
        WriteData_i = alu ^ 32'h5A5A_5A5A;
        PCPlus4_i   = alu + 32'd4;
        Zero_i      = (alu == 32'd0);
        Rd_i        = alu[4:0];
        RegWrite_i  = alu[0];
        MemWrite_i  = alu[1];
        ResultSrc_i = alu[3:2];
    endtask

    task automatic checkZeroOutputs(input string tag);
        check({tag, ".out_valid"}, 128'(out_valid), 128'(0));
        check({tag, ".in_ready"}, 128'(in_ready), 128'(1));
        check({tag, ".outputs"}, 128'(outBundle()), 128'(0));
        check({tag, ".stall_cnt"}, 128'(stall_cnt), 128'(0));
    endtask

    initial begin
        checks = 0; failures = 0; modelCnt = 0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        driveFields(32'd0);
        #12;
        reset = 1'b0;
        #1;
        checkZeroOutputs("reset");

        // T1 stream, T2 stall/skid, T3 flush while full
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mkVec(1, 1, 0, 32'(k), 1, 1, 1, 32'(k), 0));
        vecs.push_back(mkVec(0, 1, 0, 32'h0, 0, 1, 0, 32'h0, 0));
        vecs.push_back(mkVec(1, 0, 0, 32'hAAAA_0000, 1, 1, 1, 32'hAAAA_0000, 0));
        vecs.push_back(mkVec(1, 0, 0, 32'hBBBB_0000, 1, 0, 1, 32'hAAAA_0000, 1));
        vecs.push_back(mkVec(1, 0, 0, 32'hCCCC_0000, 1, 0, 1, 32'hAAAA_0000, 2));
        vecs.push_back(mkVec(1, 1, 0, 32'hCCCC_0000, 1, 1, 1, 32'hBBBB_0000, 2));
        vecs.push_back(mkVec(1, 1, 0, 32'hCCCC_0000, 1, 1, 1, 32'hCCCC_0000, 2));
        vecs.push_back(mkVec(0, 1, 0, 32'h0, 0, 1, 0, 32'h0, 2));
        vecs.push_back(mkVec(1, 0, 0, 32'h1111, 1, 1, 1, 32'h1111, 2));
        vecs.push_back(mkVec(1, 0, 0, 32'h2222, 1, 0, 1, 32'h1111, 3));
        vecs.push_back(mkVec(1, 0, 1, 32'hD, 0, 1, 0, 32'h0, 4));
        vecs.push_back(mkVec(0, 1, 0, 32'h0, 0, 1, 0, 32'h0, 4));

        foreach (vecs[i]) begin
            in_valid = vecs[i].iv; out_ready = vecs[i].oRdy; flush = vecs[i].fl;
            driveFields(vecs[i].alu);
            applyStimulus();
            check($sformatf("vec%0d.out_valid", i), 128'(out_valid), 128'(vecs[i].expOv));
            check($sformatf("vec%0d.in_ready", i), 128'(in_ready), 128'(vecs[i].expIr));
            check($sformatf("vec%0d.stall_cnt", i), 128'(stall_cnt), 128'(vecs[i].expCnt));
            if (vecs[i].chkAlu)
                check($sformatf("vec%0d.alu", i), 128'(ALUResult_o), 128'(vecs[i].expAlu));
            checkOutput($sformatf("vec%0d.model", i));
        end
        flush = 1'b0;

        // T4 control passthrough
        in_valid = 1'b1; out_ready = 1'b1;
        ALUResult_i = 32'hCAFE_0004; WriteData_i = 32'h1234_5678; PCPlus4_i = 32'h104;
        Zero_i = 1'b1; Rd_i = 5'd31; RegWrite_i = 1'b1; MemWrite_i = 1'b0; ResultSrc_i = 2'b10;
        applyStimulus();
        check("ctl.alu", 128'(ALUResult_o), 128'(32'hCAFE_0004));
        check("ctl.pc4", 128'(PCPlus4_o), 128'(32'h104));
        check("ctl.zero", 128'(Zero_o), 128'(1));
        check("ctl.rd", 128'(Rd_o), 128'(31));
        check("ctl.regwrite", 128'(RegWrite_o), 128'(1));
        check("ctl.memwrite", 128'(MemWrite_o), 128'(0));
        check("ctl.resultsrc", 128'(ResultSrc_o), 128'(2));
        checkOutput("ctl.model");
        in_valid = 1'b0;
        applyStimulus();
        checkOutput("ctl.drain");

        // Random traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 19) == 0);
            ALUResult_i = $urandom; WriteData_i = $urandom; PCPlus4_i = $urandom;
            Zero_i = 1'($urandom); Rd_i = 5'($urandom); RegWrite_i = 1'($urandom);
            MemWrite_i = 1'($urandom); ResultSrc_i = 2'($urandom);
            applyStimulus();
            checkOutput($sformatf("rnd%0d", n));
        end
        flush = 1'b0;

        // T5 counter saturation: restart from reset so the count starts at zero
        reset = 1'b1; #2; reset = 1'b0;
        modelQ.delete(); modelCnt = 0;
        in_valid = 1'b1; out_ready = 1'b0; driveFields(32'h55);
        applyStimulus();
        in_valid = 1'b0;
        for (int n = 0; n < 20; n++) applyStimulus();
        check("sat.stall_cnt", 128'(stall_cnt), 128'(CNT_MAX));
        checkOutput("sat.model");

        // T6 asynchronous reset while FULL, checked before the next edge
        in_valid = 1'b1; driveFields(32'h77);
        applyStimulus();
        check("full.in_ready", 128'(in_ready), 128'(0));
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkZeroOutputs("areset");
        #2;
        reset = 1'b0;
        modelQ.delete(); modelCnt = 0;
        out_ready = 1'b1;
        applyStimulus();
        checkOutput("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
